// File: rtl/ps2_decimal_entry.sv
// ps2_decimal_entry: collects decimal digits from PS/2 scan codes, converts
// them with a sequential multiply-accumulate and commits a clamped value.
module ps2_decimal_entry #(
  parameter int NUM_DIGITS = 3,
  parameter int MAX_VALUE  = 100,
  parameter int OUT_WIDTH  = 8,
  localparam int CW    = $clog2(NUM_DIGITS + 1),
  localparam int ACC_W = 4 * NUM_DIGITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_key_pressed,
  input  logic [7:0]           i_received_data,
  output logic [OUT_WIDTH-1:0] o_value_out,
  output logic                 o_value_valid,
  output logic                 o_clamped,
  output logic [CW-1:0]        o_digit_count,
  output logic                 o_busy
);
  typedef enum logic [1:0] {S_COLLECT, S_CONV, S_PUSH} state_t;
  state_t                r_state, w_state_nxt;
  logic [ACC_W-1:0]      r_buf;
  logic [CW-1:0]         r_count, r_idx;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_brk, r_valid, r_clamped;
  logic [OUT_WIDTH-1:0]  r_value;
  logic                  w_key, w_is_digit, w_enter;
  logic [3:0]            w_digit, w_cur;
  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (i_received_data)
      8'h45, 8'h70: w_digit = 4'd0;
      8'h16: w_digit = 4'd1;
      8'h1E: w_digit = 4'd2;
      8'h26: w_digit = 4'd3;
      8'h25: w_digit = 4'd4;
      8'h2E: w_digit = 4'd5;
      8'h36: w_digit = 4'd6;
      8'h3D: w_digit = 4'd7;
      8'h3E: w_digit = 4'd8;
      8'h46: w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end
  // a byte that reaches the decoder: not busy, not swallowed by a break, not a prefix
  assign w_key   = i_key_pressed && r_state == S_COLLECT && !r_brk &&
                   i_received_data != 8'hF0 && i_received_data != 8'hE0;
  assign w_enter = w_key && i_received_data == 8'h5A && r_count != '0;
  assign w_cur   = r_buf[r_idx*4 +: 4];
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: w_state_nxt = w_enter ? S_CONV : S_COLLECT;
      S_CONV:    w_state_nxt = (r_idx + CW'(1) == r_count) ? S_PUSH : S_CONV;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_COLLECT;
    else r_state <= w_state_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf     <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_brk     <= 1'b0;
      r_valid   <= 1'b0;
      r_clamped <= 1'b0;
      r_value   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          r_acc <= '0;
          r_idx <= '0;
          if (i_key_pressed)
            r_brk <= r_brk ? 1'b0 : i_received_data == 8'hF0;
          if (w_key && w_is_digit && r_count < CW'(NUM_DIGITS)) begin
            r_buf[r_count*4 +: 4] <= w_digit;
            r_count <= r_count + CW'(1);
          end else if (w_key && i_received_data == 8'h66 && r_count != '0)
            r_count <= r_count - CW'(1);
          else if (w_key && i_received_data == 8'h76)
            r_count <= '0;
        end
        S_CONV: begin
          r_acc <= r_acc * ACC_W'(10) + ACC_W'(w_cur);
          r_idx <= r_idx + CW'(1);
        end
        S_PUSH: begin
          r_value   <= (32'(r_acc) > MAX_VALUE) ? OUT_WIDTH'(MAX_VALUE) : OUT_WIDTH'(r_acc);
          r_clamped <= 32'(r_acc) > MAX_VALUE;
          r_valid   <= 1'b1;
          r_count   <= '0;
        end
        default: ;
      endcase
    end
  end
  assign o_value_out   = r_value;
  assign o_value_valid = r_valid;
  assign o_clamped     = r_clamped;
  assign o_digit_count = r_count;
  assign o_busy        = r_state != S_COLLECT;
endmodule

// File: doc/ps2_decimal_entry.md
Name: ps2_decimal_entry

Overview:
- Parametrised decimal-entry front end for the PS/2 keyboard path.
- Collects up to NUM_DIGITS decimal digits from scan codes and filters break (F0) and extended (E0) prefixes.
- Supports Backspace and Escape editing; converts the buffer with a sequential multiply-accumulate and clamps to MAX_VALUE.
- Presents the result as a one-cycle valid pulse to the effect-parameter registers.

Parameters:
NUM_DIGITS, 3, maximum digits held in the entry buffer (1..6)
MAX_VALUE, 100, clamp ceiling applied to the converted value
OUT_WIDTH, 8, width of value_out; MAX_VALUE must fit in OUT_WIDTH bits

Ports:
Clock  input  1  system clock, all state on rising edge
Reset_n  input  1  asynchronous active-low reset
key_pressed  input  1  one-cycle strobe: received_data holds a new scan-code byte
received_data  input  8  scan-code byte from the PS/2 receiver
value_out  output  OUT_WIDTH  last committed, clamped value
value_valid  output  1  one-cycle pulse when value_out updates
clamped  output  1  high if the last commit exceeded MAX_VALUE; held until next commit
digit_count  output  clog2(NUM_DIGITS+1)  digits currently buffered
busy  output  1  high while in CONV or PUSH; key strobes are dropped while high

Behaviour:
- Reset: state=COLLECT; buffer, digit_count, value_out, value_valid, clamped, busy, break_pending and ext_pending all cleared to 0.
- Reset is honoured mid-conversion: the partial result is discarded and no pulse is issued.
- Accumulator width: ACC_W = 4*NUM_DIGITS, internal only.
- Conversion arithmetic: acc <= acc*10 + digit, computed at ACC_W bits with no truncation.
- Scan-code filter (COLLECT only, evaluated on key_pressed):
  - Byte 0xF0: set break_pending; the next byte is consumed silently and clears break_pending (ext_pending also cleared).
  - Byte 0xE0: set ext_pending; the next non-F0 byte is decoded normally, then ext_pending is cleared. This means keypad Enter (E0 5A) acts as Enter.
  - Digit map: 0x45 or 0x70 = 0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9. Both top-row and keypad codes are accepted for 0; top-row codes for 1-9.
  - Digit with digit_count<NUM_DIGITS: stored at buffer[digit_count]; digit_count+1.
  - Digit with buffer full: ignored, no state change.
  - 0x66 Backspace: digit_count-1 if nonzero; no-op when empty.
  - 0x76 Escape: digit_count<=0.
  - 0x5A Enter with digit_count>0: go to CONV.
  - 0x5A Enter with digit_count==0: ignored, no pulse.
  - All other bytes: ignored.
- CONV (busy=1):
  - On entry: acc=0, idx=0.
  - Each cycle: acc<=acc*10+buffer[idx], idx+1.
  - After digit_count cycles, go to PUSH.
- PUSH (busy=1, one cycle):
  - value_out<=min(acc,MAX_VALUE); clamped<=(acc>MAX_VALUE); value_valid=1 registered for exactly this cycle; digit_count<=0.
  - Next state: COLLECT.
- Latency: Enter strobe sampled at edge T; value_valid is high during cycle T+digit_count+1.
- Key strobes arriving while busy are dropped, including F0/E0 prefixes. Prefix flags keep their values across CONV and PUSH.
- value_valid never asserts for two consecutive cycles.
- value_out is unchanged between commits.

Test Plan:
1. Reset, then keys 16,1E,26 (1,2,3), then 5A, with F0 break pairs interleaved -> value_valid pulse 4 cycles after Enter; value_out=100, clamped=1; the break bytes create no extra digits.
2. Keys 2E,45 (5,0) then 5A -> value_out=50, clamped=0, digit_count returns to 0, pulse 3 cycles after Enter.
3. Keys 3E,46,66,16 (8,9,Bksp,1) then E0 5A (keypad Enter) -> value_out=81; digit_count sequence 1,2,1,2,0.
4. Keys 1E,1E,1E,1E (four 2s, NUM_DIGITS=3) then 5A -> fourth digit ignored; acc=222; value_out=100, clamped=1.
5. Lone 5A; key 26 then 76 then 5A -> no value_valid pulse in either case; value_out keeps its prior value.
6. Keys 26,5A, then Reset_n low for 1 cycle during CONV; separately, key strobe 16 during CONV with reset held high -> after the reset: no pulse, all outputs 0. For the strobe during CONV: strobe dropped, value_out=3.
